fp32_add_arbiter: RTL and testbench
===================================

Name: fp32_add_arbiter

Overview:
- Shares one pipelined fp32 adder (valid-in / done-out, in-order results, no input stall) among NUM_REQ requesters.
- Round-robin grants at most one operation per cycle into the adder and records the requester ID in an in-order tag FIFO.
- Routes each adder result plus its overflow/underflow/invalid flags back to the requester that issued it.
- Sits between the arithmetic clients and the fp32 adder in the datapath top level.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
MAX_OUTSTANDING, 8, max operations in flight in the adder; tag FIFO depth; power of two
WIDTH, 32, operand width

Ports:
clk  in  1  clock
rstn  in  1  synchronous active-low reset
req_valid  in  NUM_REQ  per-requester operation valid
req_ready  out  NUM_REQ  per-requester accept; operation transfers when valid&ready
req_a  in  NUM_REQ*WIDTH  operand A, requester i at [i*WIDTH +: WIDTH]
req_b  in  NUM_REQ*WIDTH  operand B, same packing
rsp_valid  out  NUM_REQ  one-hot result strobe, one cycle, no backpressure
rsp_result  out  WIDTH  result word, shared by all requesters
rsp_flags  out  3  {overflow, underflow, invalid}
add_valid_o  out  1  adder issue strobe
add_a_o  out  WIDTH  adder operand A
add_b_o  out  WIDTH  adder operand B
add_result_i  in  WIDTH  adder result
add_done_i  in  1  adder result valid
add_flags_i  in  3  adder {overflow, underflow, invalid}
outstanding_o  out  $clog2(MAX_OUTSTANDING)+1  operations in flight
err_orphan_o  out  1  sticky: add_done_i seen with empty tag FIFO

Behaviour:
- Reset: rstn is synchronous and active-low; clock is clk. During reset, all outputs are 0, the RR pointer is 0, the tag FIFO is empty and the outstanding count is 0. Reset mid-operation discards all in-flight tags. The adder shares rstn, so its pipeline is flushed in the same cycle.
- Credit: can_issue = (outstanding < MAX_OUTSTANDING).
- Arbitration (combinational):
  - Search req_valid starting at the RR pointer, wrapping modulo NUM_REQ; the first set bit wins.
  - req_ready = onehot(winner) & {NUM_REQ{can_issue}}.
  - If can_issue=0, all req_ready are 0.
- Issue (registered, 1-cycle latency):
  - On handshake, next cycle: add_valid_o=1, and add_a_o/add_b_o carry the winner's operands.
  - The RR pointer moves to winner+1 (mod NUM_REQ).
  - The winner ID is pushed into the tag FIFO.
  - With no handshake, add_valid_o=0, the operands hold their last value and the pointer holds.
- Return (registered, 1-cycle latency after add_done_i):
  - Pop the tag FIFO.
  - rsp_valid = onehot(tag); rsp_result = add_result_i; rsp_flags = add_flags_i.
  - Otherwise rsp_valid=0; rsp_result and rsp_flags hold.
- Orphan done: if the FIFO is empty when add_done_i=1, there is no pop and rsp_valid=0. err_orphan_o is set and stays set until reset.
- Outstanding count:
  - +1 on handshake, -1 on valid pop; both in the same cycle leaves it unchanged.
  - Push into a full FIFO is impossible by credit.
  - Simultaneous push and pop with the FIFO full (outstanding==MAX) cannot occur, because no handshake is allowed at MAX. A pop that makes room is visible to can_issue on the following cycle only.
- FIFO pointers: log2(MAX_OUTSTANDING) bits, wrap naturally; full/empty derive from the count.
- Throughput: one issue per cycle sustained with any number of valid requesters. A requester held valid is granted within NUM_REQ issue cycles.
- req_a/req_b are sampled only on handshake; operand changes while not ready are ignored.

Decomposition:
- Package fp32_arb_pkg:
  - flag index constants (FLAG_OVF=2, FLAG_UNF=1, FLAG_INV=0)
  - typedef fp32_t (logic [31:0])
  - typedef struct {fp32_t a; fp32_t b;} fp32_op_t
- Sub-module: fp32_tag_fifo, a synchronous FIFO of requester IDs, depth MAX_OUTSTANDING, with push/pop/count/empty/full.
- Arbiter and credit logic stay in the top module.

Test Plan:
- Single request: req0 A=3F800000, B=40000000 behind a real fp32 adder -> req_ready[0]=1 for one cycle, add_valid_o next cycle; later rsp_valid=0001, rsp_result=40400000, rsp_flags=000.
- All 4 requesters valid continuously, distinct operands -> issue order 0,1,2,3,0,...; each rsp_valid bit matches issue order; results equal the C reference within 2 ULP.
- Stub adder that never asserts done; all requesters valid -> exactly 8 issues; outstanding_o=8; req_ready=0 thereafter. One done -> outstanding_o=7 and exactly one further issue.
- Special cases: req2 7F800000+FF800000 -> rsp_valid=0100, NaN result, rsp_flags[0]=1. req1 7F7FFFFF+7F7FFFFF -> rsp_result=7F800000, rsp_flags[2]=1.
- Stub adder pulses add_done_i with nothing issued -> rsp_valid=0, err_orphan_o=1 and it stays 1 until rstn=0.
- Reset with 5 in flight -> next cycle outstanding_o=0, rsp_valid=0, RR pointer=0. The first request after reset from req3 (only valid) is granted.

Source files
------------

// File: rtl/fp32_arb_pkg.sv
// fp32_arb_pkg
//   Shared types and constants for the fp32 adder arbiter slice.
//   - FLAG_* : bit positions inside the 3-bit {overflow, underflow, invalid} flag word
//   - fp32_t : raw IEEE-754 single-precision word
//   - fp32_op_t : operand pair handed to the adder
package fp32_arb_pkg;

  localparam int FLAG_OVF = 2;
  localparam int FLAG_UNF = 1;
  localparam int FLAG_INV = 0;
  localparam int FLAG_W   = 3;

  typedef logic [31:0] fp32_t;

  typedef struct packed {
    fp32_t a;
    fp32_t b;
  } fp32_op_t;

endpackage

// File: rtl/fp32_tag_fifo.sv
// fp32_tag_fifo
//   In-order FIFO of requester IDs, one entry per operation in flight in the
//   shared adder. Because the adder returns results in issue order, the head
//   entry always names the owner of the next result.
// Ports:
//   clk, rstn  : clock, synchronous active-low reset (empties the FIFO)
//   push       : write push_data at the tail (ignored when full)
//   push_data  : requester ID to record
//   pop        : drop the head entry (ignored when empty)
//   pop_data   : current head entry (valid when !empty)
//   count      : number of stored entries, 0..DEPTH
//   empty/full : derived from count
module fp32_tag_fifo #(
  parameter int DEPTH  = 8,
  parameter int DATA_W = 2,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] pop_data,
  output logic [CW-1:0]     count,
  output logic              empty,
  output logic              full
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign empty    = (count == '0);
  assign full     = (count == CW'(DEPTH));
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  // Pointers are exactly log2(DEPTH) bits wide so they wrap on their own;
  // occupancy is tracked separately in count, which disambiguates full/empty.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/fp32_add_arbiter.sv
// fp32_add_arbiter
//   Shares one pipelined, in-order fp32 adder among NUM_REQ requesters.
//   A round-robin arbiter grants at most one operation per cycle, limited by a
//   credit of MAX_OUTSTANDING operations in flight. The winner's ID is queued in
//   an in-order tag FIFO so every result can be routed back to its issuer.
// Ports:
//   clk, rstn        : clock, synchronous active-low reset
//   req_valid/ready  : per-requester handshake, transfer on valid & ready
//   req_a, req_b     : packed operands, requester i at [i*WIDTH +: WIDTH]
//   rsp_valid        : one-hot, single-cycle result strobe
//   rsp_result/flags : shared result word and {overflow, underflow, invalid}
//   add_valid_o, add_a_o, add_b_o          : issue side of the adder
//   add_done_i, add_result_i, add_flags_i  : return side of the adder
//   outstanding_o    : operations currently in flight
//   err_orphan_o     : sticky, a result arrived with no matching tag
module fp32_add_arbiter
  import fp32_arb_pkg::*;
#(
  parameter int NUM_REQ         = 4,
  parameter int MAX_OUTSTANDING = 8,
  parameter int WIDTH           = 32,
  localparam int ID_W           = $clog2(NUM_REQ),
  localparam int CW             = $clog2(MAX_OUTSTANDING) + 1
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*WIDTH-1:0] req_a,
  input  logic [NUM_REQ*WIDTH-1:0] req_b,
  output logic [NUM_REQ-1:0]       rsp_valid,
  output logic [WIDTH-1:0]         rsp_result,
  output logic [FLAG_W-1:0]        rsp_flags,
  output logic                     add_valid_o,
  output logic [WIDTH-1:0]         add_a_o,
  output logic [WIDTH-1:0]         add_b_o,
  input  logic [WIDTH-1:0]         add_result_i,
  input  logic                     add_done_i,
  input  logic [FLAG_W-1:0]        add_flags_i,
  output logic [CW-1:0]            outstanding_o,
  output logic                     err_orphan_o
);

  logic [ID_W-1:0] rr_ptr;
  logic [ID_W-1:0] winner;
  logic [ID_W-1:0] tag_head;
  logic            found;
  logic            can_issue;
  logic            handshake;
  logic            tag_pop;
  logic            fifo_empty;
  logic            fifo_full;

  // The FIFO holds exactly one entry per operation in flight, so "not full"
  // is the same as outstanding < MAX_OUTSTANDING.
  assign can_issue = !fifo_full;

  // Rotating priority search: scan from rr_ptr upward, wrapping at NUM_REQ,
  // and take the first valid requester. Works for non-power-of-two NUM_REQ.
  always_comb begin
    int idx;
    idx    = 0;
    winner = '0;
    found  = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!found && req_valid[idx]) begin
        found  = 1'b1;
        winner = ID_W'(idx);
      end
    end
  end

  // Ready is held low in reset so nothing can be pushed while the FIFO clears.
  assign req_ready = (rstn && found && can_issue) ? (NUM_REQ'(1) << winner) : '0;
  assign handshake = |(req_valid & req_ready);

  // A done with an empty FIFO has no owner; it is flagged, never popped.
  assign tag_pop = add_done_i && !fifo_empty;

  fp32_tag_fifo #(
    .DEPTH  (MAX_OUTSTANDING),
    .DATA_W (ID_W)
  ) u_tag_fifo (
    .clk       (clk),
    .rstn      (rstn),
    .push      (handshake),
    .push_data (winner),
    .pop       (tag_pop),
    .pop_data  (tag_head),
    .count     (outstanding_o),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

  // Issue stage: operands are captured only on a handshake, and the pointer
  // moves just past the winner so it becomes lowest priority next time.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      add_valid_o <= 1'b0;
      add_a_o     <= '0;
      add_b_o     <= '0;
      rr_ptr      <= '0;
    end else begin
      add_valid_o <= handshake;
      if (handshake) begin
        add_a_o <= req_a[int'(winner)*WIDTH +: WIDTH];
        add_b_o <= req_b[int'(winner)*WIDTH +: WIDTH];
        rr_ptr  <= (winner == ID_W'(NUM_REQ - 1)) ? '0 : winner + ID_W'(1);
      end
    end
  end

  // Return stage: route each in-order result to the ID at the FIFO head.
  // Result and flags hold between strobes, including across orphan dones.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      rsp_valid    <= '0;
      rsp_result   <= '0;
      rsp_flags    <= '0;
      err_orphan_o <= 1'b0;
    end else begin
      rsp_valid <= tag_pop ? (NUM_REQ'(1) << tag_head) : '0;
      if (tag_pop) begin
        rsp_result <= add_result_i;
        rsp_flags  <= add_flags_i;
      end
      if (add_done_i && fifo_empty) err_orphan_o <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fp32_add_arbiter.sv
// tb_fp32_add_arbiter
//   Drives fp32_add_arbiter with directed and $urandom stimulus, with a
//   behavioural fp32 adder hanging off the adder port (normal latency, hold,
//   single-result release and orphan-pulse modes). A transaction-level model
//   predicts grants, issued operands, routed results and the credit count.
module tb_fp32_add_arbiter;
  import fp32_arb_pkg::*;

  localparam int N   = 4;
  localparam int MAX = 8;
  localparam int W   = 32;
  localparam int LAT = 3;

  logic             clk = 1'b0;
  logic             rstn;
  logic [N-1:0]     req_valid;
  logic [N-1:0]     req_ready;
  logic [N*W-1:0]   req_a;
  logic [N*W-1:0]   req_b;
  logic [N-1:0]     rsp_valid;
  logic [W-1:0]     rsp_result;
  logic [2:0]       rsp_flags;
  logic             add_valid_o;
  logic [W-1:0]     add_a_o;
  logic [W-1:0]     add_b_o;
  logic [W-1:0]     add_result_i = '0;
  logic             add_done_i   = 1'b0;
  logic [2:0]       add_flags_i  = '0;
  logic [3:0]       outstanding_o;
  logic             err_orphan_o;

  fp32_add_arbiter #(
    .NUM_REQ         (N),
    .MAX_OUTSTANDING (MAX),
    .WIDTH           (W)
  ) dut (
    .clk           (clk),
    .rstn          (rstn),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_a         (req_a),
    .req_b         (req_b),
    .rsp_valid     (rsp_valid),
    .rsp_result    (rsp_result),
    .rsp_flags     (rsp_flags),
    .add_valid_o   (add_valid_o),
    .add_a_o       (add_a_o),
    .add_b_o       (add_b_o),
    .add_result_i  (add_result_i),
    .add_done_i    (add_done_i),
    .add_flags_i   (add_flags_i),
    .outstanding_o (outstanding_o),
    .err_orphan_o  (err_orphan_o)
  );

  always #5 clk = ~clk;

  // fp32 -> real, denormals treated as zero (stimulus never produces them)
  function automatic real f2r(input logic [31:0] f);
    logic [63:0] d;
    if (f[30:23] == 8'hFF)      d = {f[31], 11'h7FF, f[22:0], 29'd0};
    else if (f[30:23] == 8'h00) d = {f[31], 63'd0};
    else                        d = {f[31], {3'b000, f[30:23]} + 11'd896, f[22:0], 29'd0};
    return $bitstoreal(d);
  endfunction

  // Reference fp32 add: exact-ish sum in double, round-to-nearest-even to
  // single. Returns {overflow, underflow, invalid, result}.
  function automatic logic [34:0] fadd(input logic [31:0] a, input logic [31:0] b);
    real         s;
    logic [63:0] d;
    logic [31:0] r;
    logic [30:0] mag;
    logic        ovf, unf, inv;
    int          e;
    s = f2r(a) + f2r(b);
    d = $realtobits(s);
    ovf = 1'b0; unf = 1'b0; inv = 1'b0;
    mag = '0;
    if (d[62:52] == 11'h7FF) begin
      if (d[51:0] != 52'd0) begin r = 32'h7FC00000; inv = 1'b1; end
      else r = {d[63], 8'hFF, 23'd0};
    end else if (d[62:52] == 11'd0) begin
      r = {d[63], 31'd0};
    end else begin
      e = int'(d[62:52]) - 896;
      if (e >= 255) begin
        r = {d[63], 8'hFF, 23'd0}; ovf = 1'b1;
      end else if (e <= 0) begin
        r = {d[63], 31'd0}; unf = 1'b1;
      end else begin
        mag = {e[7:0], d[51:29]};
        if (d[28] && ((|d[27:0]) || d[29])) mag = mag + 31'd1;
        if (mag[30:23] == 8'hFF) ovf = 1'b1;
        r = {d[63], mag};
      end
    end
    return {ovf, unf, inv, r};
  endfunction

  function automatic logic [31:0] randFloat();
    logic [31:0] f;
    f[31]    = 1'($urandom);
    f[30:23] = 8'(100 + $urandom_range(0, 50));
    f[22:0]  = 23'($urandom);
    return f;
  endfunction

  function automatic logic [N*W-1:0] randBus();
    logic [N*W-1:0] v;
    v = '0;
    for (int i = 0; i < N; i++) v[i*W +: W] = randFloat();
    return v;
  endfunction

  function automatic logic [N*W-1:0] slotBus(input int i, input logic [31:0] x);
    logic [N*W-1:0] v;
    v = randBus();
    v[i*W +: W] = x;
    return v;
  endfunction

  // ---------------- behavioural adder on the adder port ----------------
  typedef struct {
    fp32_op_t op;
    int       stamp;
  } adder_op_t;

  adder_op_t adder_q[$];
  int        cyc         = 0;
  logic      hold        = 1'b0;
  int        release_req = 0;
  int        release_done = 0;
  int        orphan_req  = 0;
  int        orphan_done = 0;

  // Shares rstn with the arbiter: reset flushes its pipeline as well.
  always @(posedge clk) begin
    cyc        <= cyc + 1;
    add_done_i <= 1'b0;
    if (!rstn) begin
      adder_q.delete();
      release_done <= release_req;
      orphan_done  <= orphan_req;
    end else begin
      if (orphan_done != orphan_req) begin
        add_done_i   <= 1'b1;
        add_result_i <= 32'hDEADBEEF;
        add_flags_i  <= 3'b111;
        orphan_done  <= orphan_done + 1;
      end else if (adder_q.size() > 0 &&
                   (hold ? (release_done != release_req) : (cyc >= adder_q[0].stamp + LAT))) begin
        {add_flags_i, add_result_i} <= fadd(adder_q[0].op.a, adder_q[0].op.b);
        add_done_i <= 1'b1;
        void'(adder_q.pop_front());
        if (hold) release_done <= release_done + 1;
      end
      if (add_valid_o) adder_q.push_back('{op: '{a: add_a_o, b: add_b_o}, stamp: cyc});
    end
  end

  // ---------------- reference model state ----------------
  typedef struct {
    int       id;
    fp32_op_t op;
  } tag_t;

  tag_t         ref_q[$];
  int           ref_ptr       = 0;
  int           ref_out       = 0;
  logic         ref_orphan    = 1'b0;
  logic         exp_add_valid = 1'b0;
  logic [31:0]  exp_add_a     = '0;
  logic [31:0]  exp_add_b     = '0;
  logic [N-1:0] exp_rsp_valid = '0;
  logic [31:0]  exp_rsp_result = '0;
  logic [2:0]   exp_rsp_flags = '0;

  int          passed    = 0;
  int          total     = 0;
  int          issue_cnt = 0;
  logic [31:0] last_res   [N];
  logic [2:0]  last_flags [N];
  int          rsp_seen   [N];

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    total++;
    assert (observed === expected) passed++;
    else $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
  endtask

  // Compare every output with the model at mid-cycle, then advance the model
  // by what the coming clock edge should do.
  task automatic modelStep();
    logic [N-1:0] exp_ready;
    logic [34:0]  fr;
    int           win;
    tag_t         t;
    exp_ready = '0;
    win       = -1;
    if (rstn && ref_out < MAX) begin
      for (int k = 0; k < N; k++) begin
        int idx;
        idx = (ref_ptr + k) % N;
        if (win < 0 && req_valid[idx]) win = idx;
      end
    end
    if (win >= 0) exp_ready[win] = 1'b1;

    checkOutput("req_ready",     64'(req_ready),     64'(exp_ready));
    checkOutput("add_valid_o",   64'(add_valid_o),   64'(exp_add_valid));
    checkOutput("add_a_o",       64'(add_a_o),       64'(exp_add_a));
    checkOutput("add_b_o",       64'(add_b_o),       64'(exp_add_b));
    checkOutput("rsp_valid",     64'(rsp_valid),     64'(exp_rsp_valid));
    checkOutput("rsp_result",    64'(rsp_result),    64'(exp_rsp_result));
    checkOutput("rsp_flags",     64'(rsp_flags),     64'(exp_rsp_flags));
    checkOutput("outstanding_o", 64'(outstanding_o), 64'(ref_out));
    checkOutput("err_orphan_o",  64'(err_orphan_o),  64'(ref_orphan));

    if (add_valid_o === 1'b1) issue_cnt++;
    for (int i = 0; i < N; i++) begin
      if (rsp_valid[i] === 1'b1) begin
        last_res[i]   = rsp_result;
        last_flags[i] = rsp_flags;
        rsp_seen[i]++;
      end
    end

    if (!rstn) begin
      ref_q.delete();
      ref_ptr = 0; ref_out = 0; ref_orphan = 1'b0;
      exp_add_valid = 1'b0; exp_add_a = '0; exp_add_b = '0;
      exp_rsp_valid = '0; exp_rsp_result = '0; exp_rsp_flags = '0;
    end else begin
      exp_rsp_valid = '0;
      if (add_done_i) begin
        if (ref_q.size() > 0) begin
          t  = ref_q.pop_front();
          fr = fadd(t.op.a, t.op.b);
          exp_rsp_valid[t.id] = 1'b1;
          exp_rsp_result = fr[31:0];
          exp_rsp_flags  = fr[34:32];
          ref_out--;
        end else begin
          ref_orphan = 1'b1;
        end
      end
      exp_add_valid = 1'b0;
      if (win >= 0) begin
        exp_add_valid = 1'b1;
        exp_add_a = req_a[win*W +: W];
        exp_add_b = req_b[win*W +: W];
        ref_q.push_back('{id: win, op: '{a: exp_add_a, b: exp_add_b}});
        ref_ptr = (win + 1) % N;
        ref_out++;
      end
    end
  endtask

  task automatic applyStimulus(input logic [N-1:0] v, input logic [N*W-1:0] a,
                               input logic [N*W-1:0] b, input logic rst_n);
    rstn      = rst_n;
    req_valid = v;
    req_a     = a;
    req_b     = b;
    @(negedge clk);
    modelStep();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      last_res[i] = '0; last_flags[i] = '0; rsp_seen[i] = 0;
    end
    rstn = 1'b0; req_valid = '0; req_a = '0; req_b = '0;
    @(posedge clk);
    #1;

    // Reset state
    repeat (3) applyStimulus('0, randBus(), randBus(), 1'b0);
    checkOutput("reset_outstanding", 64'(outstanding_o), 64'd0);
    checkOutput("reset_rsp_valid",   64'(rsp_valid),     64'd0);

    // Single request from requester 0: 1.0 + 2.0
    applyStimulus(4'b0001, slotBus(0, 32'h3F800000), slotBus(0, 32'h40000000), 1'b1);
    repeat (8) applyStimulus('0, randBus(), randBus(), 1'b1);
    checkOutput("single_rsp_result", 64'(last_res[0]),   64'h40400000);
    checkOutput("single_rsp_flags",  64'(last_flags[0]), 64'd0);
    checkOutput("single_rsp_count",  64'(rsp_seen[0]),   64'd1);

    // All requesters valid, operands changing every cycle
    repeat (40) applyStimulus(4'hF, randBus(), randBus(), 1'b1);
    // Random valid patterns
    repeat (60) applyStimulus(N'($urandom), randBus(), randBus(), 1'b1);
    repeat (10) applyStimulus('0, randBus(), randBus(), 1'b1);

    // Credit limit: adder never returns
    hold = 1'b1;
    issue_cnt = 0;
    repeat (16) applyStimulus(4'hF, randBus(), randBus(), 1'b1);
    checkOutput("stall_issues",      64'(issue_cnt),     64'd8);
    checkOutput("stall_outstanding", 64'(outstanding_o), 64'd8);
    checkOutput("stall_ready",       64'(req_ready),     64'd0);
    release_req++;
    repeat (6) applyStimulus(4'hF, randBus(), randBus(), 1'b1);
    checkOutput("release_issues",      64'(issue_cnt),     64'd9);
    checkOutput("release_outstanding", 64'(outstanding_o), 64'd8);
    hold = 1'b0;
    repeat (20) applyStimulus('0, randBus(), randBus(), 1'b1);
    checkOutput("drained_outstanding", 64'(outstanding_o), 64'd0);

    // Special cases: inf + -inf on requester 2, max + max on requester 1
    applyStimulus(4'b0100, slotBus(2, 32'h7F800000), slotBus(2, 32'hFF800000), 1'b1);
    repeat (6) applyStimulus('0, randBus(), randBus(), 1'b1);
    checkOutput("inf_minus_inf_nan",
                64'((last_res[2][30:23] == 8'hFF) && (last_res[2][22:0] != 23'd0)), 64'd1);
    checkOutput("inf_minus_inf_invalid", 64'(last_flags[2][FLAG_INV]), 64'd1);
    applyStimulus(4'b0010, slotBus(1, 32'h7F7FFFFF), slotBus(1, 32'h7F7FFFFF), 1'b1);
    repeat (6) applyStimulus('0, randBus(), randBus(), 1'b1);
    checkOutput("max_plus_max_result",   64'(last_res[1]),             64'h7F800000);
    checkOutput("max_plus_max_overflow", 64'(last_flags[1][FLAG_OVF]), 64'd1);

    // Orphan done with nothing in flight
    hold = 1'b1;
    orphan_req++;
    repeat (4) applyStimulus('0, randBus(), randBus(), 1'b1);
    checkOutput("orphan_err", 64'(err_orphan_o), 64'd1);
    repeat (10) applyStimulus('0, randBus(), randBus(), 1'b1);
    checkOutput("orphan_sticky", 64'(err_orphan_o), 64'd1);

    // Reset with five operations in flight
    repeat (5) applyStimulus(4'hF, randBus(), randBus(), 1'b1);
    checkOutput("inflight_before_reset", 64'(outstanding_o), 64'd5);
    applyStimulus(4'hF, randBus(), randBus(), 1'b0);
    checkOutput("reset_clears_outstanding", 64'(outstanding_o), 64'd0);
    checkOutput("reset_clears_rsp_valid",   64'(rsp_valid),     64'd0);
    checkOutput("reset_clears_orphan",      64'(err_orphan_o),  64'd0);
    hold = 1'b0;
    rstn = 1'b1;
    req_valid = 4'b1000;
    #1;
    checkOutput("post_reset_req3_ready", 64'(req_ready), 64'b1000);
    applyStimulus(4'b1000, randBus(), randBus(), 1'b1);
    applyStimulus(4'hF, randBus(), randBus(), 1'b1);
    repeat (12) applyStimulus('0, randBus(), randBus(), 1'b1);
    checkOutput("final_outstanding", 64'(outstanding_o), 64'd0);

    $display("[TB] stimulus complete");
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
